dds_wave_gen: RTL and testbench

Waveform synthesis stage directly downstream of the key-driven waveform selector. It consumes the one-hot wave_sel code (0001 sine, 0010 sawtooth, 0100 triangle, 1000 square) and runs a phase accumulator. It produces DAC sample words every clock. Sine samples come from an external synchronous-read ROM; sawtooth, triangle and square are derived arithmetically from the phase. Selection changes take effect only at a phase wrap, so the output never glitches mid-period.

---
 rtl/dds_wave_gen.sv | 113 +++++++++++
 tb/tb_dds_wave_gen.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_wave_gen.sv
// Phase-accumulator waveform generator: sine from an external synchronous ROM,
// saw/triangle/square derived from the phase. Waveform switches only at a phase wrap.
module dds_wave_gen #(
    parameter int PHASE_W = 32,
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 10
) (
    input  logic               sys_clk,
    input  logic               rst_n,
    input  logic [3:0]         wave_sel,
    input  logic [PHASE_W-1:0] freq_word,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [DATA_W-1:0]  rom_data,
    output logic [DATA_W-1:0]  dac_data,
    output logic [3:0]         wave_active
);

    typedef enum logic [3:0] {
        WAVE_IDLE = 4'b0000,
        WAVE_SIN  = 4'b0001,
        WAVE_SAW  = 4'b0010,
        WAVE_TRI  = 4'b0100,
        WAVE_SQU  = 4'b1000
    } wave_t;

    localparam int TOP_W = DATA_W + 1;
    localparam logic [DATA_W-1:0] MIDSCALE = {1'b1, {(DATA_W-1){1'b0}}};

    // Control state
    logic [PHASE_W-1:0] phase_acc, phase_nxt;
    wave_t              active, active_nxt;
    wave_t              pending, pending_nxt;
    logic [PHASE_W:0]   phase_sum;
    logic               wrap;
    logic               req_valid;

    // Only the phase MSB plus the next DATA_W bits feed the arithmetic waveforms.
    logic [TOP_W-1:0]   ph1, ph2;
    wave_t              sel1, sel2;

    logic [DATA_W-1:0]  tri_t;
    logic [DATA_W-1:0]  saw_val, tri_val, squ_val;
    logic [DATA_W-1:0]  sample;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        req_valid   = (wave_sel != 4'b0000) && ((wave_sel & (wave_sel - 4'd1)) == 4'b0000);
        phase_sum   = {1'b0, phase_acc} + {1'b0, freq_word};
        wrap        = phase_sum[PHASE_W];
        phase_nxt   = phase_acc;
        active_nxt  = active;
        pending_nxt = pending;

        if (active == WAVE_IDLE) begin
            if (req_valid) begin
                active_nxt = wave_t'(wave_sel);
            end
        end else begin
            phase_nxt = phase_sum[PHASE_W-1:0];
            // A zero increment never wraps, so a pending switch is taken immediately.
            if ((wrap || freq_word == '0) && pending != WAVE_IDLE) begin
                active_nxt  = pending;
                pending_nxt = WAVE_IDLE;
            end else if (req_valid) begin
                pending_nxt = (wave_sel == active) ? WAVE_IDLE : wave_t'(wave_sel);
            end
        end
    end

    always_comb begin
        saw_val = ph2[TOP_W-1 -: DATA_W];
        tri_t   = ph2[DATA_W-1:0];
        tri_val = ph2[TOP_W-1] ? ~tri_t : tri_t;
        squ_val = ph2[TOP_W-1] ? '0 : '1;
        sample  = MIDSCALE;
        case (sel2)
            WAVE_SIN: sample = rom_data;
            WAVE_SAW: sample = saw_val;
            WAVE_TRI: sample = tri_val;
            WAVE_SQU: sample = squ_val;
            default:  sample = MIDSCALE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            phase_acc <= '0;
            active    <= WAVE_IDLE;
            pending   <= WAVE_IDLE;
            rom_addr  <= '0;
            ph1       <= '0;
            sel1      <= WAVE_IDLE;
            ph2       <= '0;
            sel2      <= WAVE_IDLE;
            dac_data  <= MIDSCALE;
        end else begin
            phase_acc <= phase_nxt;
            active    <= active_nxt;
            pending   <= pending_nxt;
            rom_addr  <= phase_acc[PHASE_W-1 -: ADDR_W];
            ph1       <= phase_acc[PHASE_W-1 -: TOP_W];
            sel1      <= active;
            // ROM data for ph1's address arrives alongside ph2.
            ph2       <= ph1;
            sel2      <= sel1;
            dac_data  <= sample;
        end
    end

    assign wave_active = active;

endmodule

// File: tb/tb_dds_wave_gen.sv
// Self-checking bench for dds_wave_gen: directed waveform scenarios plus a
// randomized run compared against a cycle-level behavioural model.
module tb_dds_wave_gen;

    logic        sys_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  wave_sel = 4'b0000;
    logic [31:0] freq_word = 32'd0;
    logic [9:0]  rom_addr;
    logic [7:0]  rom_data = 8'h00;
    logic [7:0]  dac_data;
    logic [3:0]  wave_active;

    logic [7:0]  rom_table [1024];

    int total = 0;
    int bad = 0;

    dds_wave_gen #(.PHASE_W(32), .DATA_W(8), .ADDR_W(10)) dut (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .wave_sel    (wave_sel),
        .freq_word   (freq_word),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .dac_data    (dac_data),
        .wave_active (wave_active)
    );

    always #5 sys_clk = ~sys_clk;

    // External sine ROM with one-cycle synchronous read.
    always @(posedge sys_clk) rom_data <= rom_table[rom_addr];

    // Behavioural reference model
    logic [31:0] m_phase = 32'd0;
    logic [3:0]  m_active = 4'd0;
    logic [3:0]  m_pending = 4'd0;
    logic [31:0] hist_phase [2] = '{32'd0, 32'd0};
    logic [3:0]  hist_sel [2] = '{4'd0, 4'd0};
    logic [7:0]  exp_dac = 8'h80;
    logic [9:0]  exp_addr = 10'd0;

    function automatic logic is_one_hot(input logic [3:0] s);
        return (s == 4'd1) || (s == 4'd2) || (s == 4'd4) || (s == 4'd8);
    endfunction

    function automatic logic [7:0] ref_sample(input logic [31:0] p, input logic [3:0] s);
        int t;
        t = int'((p >> 23) % 256);
        case (s)
            4'b0001: return rom_table[int'(p >> 22)];
            4'b0010: return 8'(p >> 24);
            4'b0100: return (p >= 32'h8000_0000) ? 8'(255 - t) : 8'(t);
            4'b1000: return (p < 32'h8000_0000) ? 8'd255 : 8'd0;
            default: return 8'h80;
        endcase
    endfunction

    always @(posedge sys_clk) begin
        logic [32:0] sum;
        if (!rst_n) begin
            m_phase = 0; m_active = 0; m_pending = 0;
            hist_phase[0] = 0; hist_phase[1] = 0;
            hist_sel[0] = 0;   hist_sel[1] = 0;
            exp_dac = 8'h80; exp_addr = 0;
        end else begin
            // Output shows the state from two cycles before this edge.
            exp_dac = ref_sample(hist_phase[0], hist_sel[0]);
            hist_phase[0] = hist_phase[1]; hist_sel[0] = hist_sel[1];
            hist_phase[1] = m_phase;       hist_sel[1] = m_active;
            exp_addr = 10'(m_phase >> 22);
            if (m_active == 0) begin
                if (is_one_hot(wave_sel)) m_active = wave_sel;
            end else begin
                sum = {1'b0, m_phase} + {1'b0, freq_word};
                m_phase = sum[31:0];
                if ((sum[32] || freq_word == 0) && m_pending != 0) begin
                    m_active = m_pending;
                    m_pending = 0;
                end else if (is_one_hot(wave_sel)) begin
                    m_pending = (wave_sel == m_active) ? 4'd0 : wave_sel;
                end
            end
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wave_sel = 4'b0000;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        freq_word = 32'h0100_0000;
        do_reset();
        total++;
        if (dac_data !== 8'h80 || wave_active !== 4'b0000 || rom_addr !== 10'd0) begin
            bad++;
            $display("FAIL reset_state: dac=%h active=%b addr=%0d, want 80/0000/0", dac_data, wave_active, rom_addr);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            total++;
            if (dac_data !== 8'h80 || wave_active !== 4'b0000 || rom_addr !== 10'd0) begin
                bad++;
                $display("FAIL idle_hold[%0d]: dac=%h active=%b addr=%0d, want 80/0000/0", i, dac_data, wave_active, rom_addr);
            end
        end
    endtask

    task automatic test_saw();
        logic [7:0] e;
        do_reset();
        freq_word = 32'h0100_0000;
        wave_sel = 4'b0010;
        tick();
        total++;
        if (wave_active !== 4'b0010) begin
            bad++;
            $display("FAIL saw_start_active: got %b want 0010", wave_active);
        end
        for (int j = 1; j <= 300; j++) begin
            if (j > 1) tick();
            e = (j < 4) ? 8'h80 : 8'(j - 4);
            total++;
            if (dac_data !== e) begin
                bad++;
                $display("FAIL saw_sample[%0d]: got %h want %h", j, dac_data, e);
            end
        end
    endtask

    task automatic test_tri();
        logic [7:0] e;
        int k;
        do_reset();
        freq_word = 32'h0100_0000;
        wave_sel = 4'b0100;
        tick();
        for (int j = 1; j <= 520; j++) begin
            if (j > 1) tick();
            k = (j - 4) % 256;
            e = (j < 4) ? 8'h80 : ((k < 128) ? 8'(2 * k) : 8'(511 - 2 * k));
            total++;
            if (dac_data !== e) begin
                bad++;
                $display("FAIL tri_sample[%0d]: got %h want %h", j, dac_data, e);
            end
        end
    endtask

    task automatic test_switch_at_wrap();
        logic [7:0] e;
        logic [3:0] ea;
        int k;
        do_reset();
        freq_word = 32'h0100_0000;
        wave_sel = 4'b0010;
        tick();
        for (int j = 1; j <= 520; j++) begin
            if (j > 1) tick();
            k = (j - 260) % 256;
            if (j < 4)         e = 8'h80;
            else if (j <= 259) e = 8'(j - 4);
            else               e = (k < 128) ? 8'hFF : 8'h00;
            ea = (j <= 256) ? 4'b0010 : 4'b1000;
            total++;
            if (dac_data !== e || wave_active !== ea) begin
                bad++;
                $display("FAIL switch[%0d]: dac=%h active=%b want %h/%b", j, dac_data, wave_active, e, ea);
            end
            // Phase here is 64 * 2^24 = 0x4000_0000.
            if (j == 65) wave_sel = 4'b1000;
        end
    endtask

    task automatic test_sine();
        logic [7:0] e;
        logic [9:0] ea;
        for (int k = 0; k < 1024; k++) rom_table[k] = 8'(k >> 2);
        do_reset();
        freq_word = 32'h0040_0000;
        wave_sel = 4'b0001;
        tick();
        for (int j = 1; j <= 1100; j++) begin
            if (j > 1) tick();
            ea = (j < 2) ? 10'd0 : 10'((j - 2) % 1024);
            e  = (j < 4) ? 8'h80 : 8'(((j - 4) % 1024) >> 2);
            total++;
            if (rom_addr !== ea || dac_data !== e) begin
                bad++;
                $display("FAIL sine[%0d]: addr=%0d dac=%h want %0d/%h", j, rom_addr, dac_data, ea, e);
            end
        end
    endtask

    task automatic test_ignore_and_reset();
        logic [7:0] e;
        do_reset();
        freq_word = 32'h0100_0000;
        wave_sel = 4'b0010;
        tick();
        for (int j = 1; j <= 300; j++) begin
            if (j > 1) tick();
            e = (j < 4) ? 8'h80 : 8'(j - 4);
            total++;
            if (dac_data !== e || wave_active !== 4'b0010) begin
                bad++;
                $display("FAIL ignore_invalid[%0d]: dac=%h active=%b want %h/0010", j, dac_data, wave_active, e);
            end
            if (j == 40) wave_sel = 4'b0101;
            if (j == 50) wave_sel = 4'b0000;
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (dac_data !== 8'h80 || wave_active !== 4'b0000 || rom_addr !== 10'd0) begin
                bad++;
                $display("FAIL midrun_reset[%0d]: dac=%h active=%b addr=%0d want 80/0000/0", i, dac_data, wave_active, rom_addr);
            end
            tick();
        end
    endtask

    task automatic test_freq_zero();
        do_reset();
        freq_word = 32'd0;
        wave_sel = 4'b0010;
        tick();
        wave_sel = 4'b1000;
        tick();
        total++;
        if (wave_active !== 4'b0010) begin
            bad++;
            $display("FAIL fz_pending_latch: got %b want 0010", wave_active);
        end
        tick();
        total++;
        if (wave_active !== 4'b1000) begin
            bad++;
            $display("FAIL fz_pending_apply: got %b want 1000", wave_active);
        end
        repeat (4) tick();
        total++;
        if (dac_data !== 8'hFF) begin
            bad++;
            $display("FAIL fz_square_level: got %h want ff", dac_data);
        end
    endtask

    task automatic test_random();
        int hold;
        int r;
        hold = 0;
        for (int k = 0; k < 1024; k++) rom_table[k] = 8'($urandom);
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            if (hold == 0) begin
                r = int'($urandom_range(0, 9));
                if (r < 7)       wave_sel = 4'b0001 << $urandom_range(0, 3);
                else if (r == 7) wave_sel = 4'b0000;
                else             wave_sel = 4'($urandom_range(3, 15)) | 4'b0011;
                if ($urandom_range(0, 15) == 0) freq_word = 32'd0;
                else                            freq_word = $urandom >> $urandom_range(0, 10);
                hold = int'($urandom_range(2, 30));
            end
            hold--;
            rst_n = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
            tick();
            total++;
            if (dac_data !== exp_dac || wave_active !== m_active || rom_addr !== exp_addr) begin
                bad++;
                $display("FAIL random[%0d]: dac=%h active=%b addr=%0d want %h/%b/%0d",
                         n, dac_data, wave_active, rom_addr, exp_dac, m_active, exp_addr);
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < 1024; k++) rom_table[k] = 8'(k >> 2);
        test_reset();
        test_saw();
        test_tri();
        test_switch_at_wrap();
        test_sine();
        test_ignore_and_reset();
        test_freq_zero();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
